quadrature_decoder: RTL and testbench

Decodes a two-channel quadrature encoder signal (A/B) into single-cycle count-step pulses plus a direction bit, directly upstream of the 32-bit up/down counter cell. Step_o drives the counter's Enable input and Direction_o drives its Direction input. Both raw inputs are asynchronous to Clk_i, so each is synchronized and then digitally glitch-filtered before decoding. Illegal double-transitions raise a sticky error flag.

---
 rtl/quadrature_decoder_if.sv | 28 ++
 rtl/quadrature_decoder.sv | 95 +++++++++
 tb/tb_quadrature_decoder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder_if
// Brief    : Control, encoder and status signals of the quadrature decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface quadrature_decoder_if;
    logic        Enable_i;
    logic        ClearError_i;
    logic        A_i;
    logic        B_i;
    logic [15:0] FilterLen_i;
    logic        Step_o;
    logic        Direction_o;
    logic        Error_o;
    logic [1:0]  State_o;

    modport master (
        output Enable_i, ClearError_i, A_i, B_i, FilterLen_i,
        input  Step_o, Direction_o, Error_o, State_o
    );

    modport slave (
        input  Enable_i, ClearError_i, A_i, B_i, FilterLen_i,
        output Step_o, Direction_o, Error_o, State_o
    );
endinterface
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder
// Brief    : Synchronized, glitch-filtered A/B quadrature decoder producing
//            step/direction pulses and a sticky illegal-transition flag.
// Revision : 1.0 - initial release
// ============================================================================
module quadrature_decoder #(
    parameter int SyncStages = 2
) (
    input wire Clk_i,
    input wire Reset_n_i,
    quadrature_decoder_if.slave bus
);

    wire [1:0] w_raw;
    wire [1:0] w_filt;
    wire [1:0] w_filt_next;

    assign w_raw = {bus.A_i, bus.B_i};

    // Index 1 carries channel A, index 0 carries channel B.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [SyncStages-1:0] r_sync;
        logic                  r_filt;
        logic [15:0]           r_cnt;
        logic                  w_sync_out;
        logic                  w_accept;

        assign w_sync_out = r_sync[SyncStages-1];
        assign w_accept   = (w_sync_out != r_filt) && (r_cnt >= bus.FilterLen_i);

        always_ff @(posedge Clk_i or negedge Reset_n_i) begin
            if (!Reset_n_i) begin
                r_sync <= '0;
                r_filt <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[SyncStages-2:0], w_raw[ch]};
                if (w_accept) begin
                    r_filt <= w_sync_out;
                    r_cnt  <= '0;
                end else if (w_sync_out == r_filt) begin
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 16'd1;
                end
            end
        end

        assign w_filt[ch]      = r_filt;
        assign w_filt_next[ch] = w_accept ? w_sync_out : r_filt;
    end

    wire [1:0] w_change;
    wire       w_single;
    wire       w_double;
    wire       w_forward;

    assign w_change = w_filt ^ w_filt_next;
    assign w_single = (w_change == 2'b01) || (w_change == 2'b10);
    assign w_double = (w_change == 2'b11);
    // Forward order 00->10->11->01: A moves when A==B, B moves when A!=B.
    assign w_forward = w_change[1] ? (w_filt[1] == w_filt[0])
                                   : (w_filt[1] != w_filt[0]);

    logic r_step;
    logic r_dir;
    logic r_err;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_step <= 1'b0;
            r_dir  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_step <= bus.Enable_i && w_single;
            if (bus.Enable_i && w_single) begin
                r_dir <= !w_forward;
            end
            if (bus.Enable_i && w_double) begin
                r_err <= 1'b1;
            end else if (bus.ClearError_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.Step_o      = r_step;
    assign bus.Direction_o = r_dir;
    assign bus.Error_o     = r_err;
    assign bus.State_o     = w_filt;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadrature_decoder
// Brief    : Directed and randomized bench for quadrature_decoder against a
//            gray-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;
    localparam int SYNC = 2;
    // Position of {A,B} along the forward cycle 00->10->11->01.
    localparam int GRAY_POS [4] = '{0, 3, 1, 2};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    quadrature_decoder_if bus ();

    quadrature_decoder #(.SyncStages(SYNC)) dut (
        .Clk_i     (clk),
        .Reset_n_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_sync [2][SYNC];
    bit m_f    [2];
    int m_run  [2];
    bit m_step, m_dir, m_err;

    int steps_seen;
    int first_edge;
    int edge_no;
    bit step_dirs [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gpos(input bit a, input bit b);
        return GRAY_POS[{a, b}];
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < SYNC; k++) m_sync[ch][k] = 1'b0;
            m_f[ch]   = 1'b0;
            m_run[ch] = 0;
        end
        m_step = 1'b0;
        m_dir  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        bit raw [2];
        bit nf  [2];
        bit s;
        int d;
        raw[0] = bus.A_i;
        raw[1] = bus.B_i;
        for (int ch = 0; ch < 2; ch++) begin
            s      = m_sync[ch][SYNC-1];
            nf[ch] = m_f[ch];
            if (s != m_f[ch]) begin
                m_run[ch]++;
                if (m_run[ch] >= int'(bus.FilterLen_i) + 1) begin
                    nf[ch]    = s;
                    m_run[ch] = 0;
                end
            end else begin
                m_run[ch] = 0;
            end
            for (int k = SYNC - 1; k > 0; k--) m_sync[ch][k] = m_sync[ch][k-1];
            m_sync[ch][0] = raw[ch];
        end
        d = (gpos(nf[0], nf[1]) - gpos(m_f[0], m_f[1]) + 4) % 4;
        m_step = bus.Enable_i && (d == 1 || d == 3);
        if (m_step) m_dir = (d == 3);
        if (bus.Enable_i && d == 2) m_err = 1'b1;
        else if (bus.ClearError_i)  m_err = 1'b0;
        m_f[0] = nf[0];
        m_f[1] = nf[1];
    endtask

    task automatic compare_outputs();
        check_eq("step",  32'(bus.Step_o),      32'(m_step));
        check_eq("dir",   32'(bus.Direction_o), 32'(m_dir));
        check_eq("error", 32'(bus.Error_o),     32'(m_err));
        check_eq("state", 32'(bus.State_o),     32'({m_f[0], m_f[1]}));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        edge_no++;
        compare_outputs();
        if (bus.Step_o) begin
            steps_seen++;
            step_dirs.push_back(bus.Direction_o);
            if (first_edge < 0) first_edge = edge_no;
        end
    endtask

    task automatic new_seg();
        steps_seen = 0;
        first_edge = -1;
        edge_no    = 0;
        step_dirs.delete();
    endtask

    task automatic drive_hold(input bit a, input bit b, input int n);
        bus.A_i = a;
        bus.B_i = b;
        repeat (n) tick();
    endtask

    initial begin
        bit [1:0] cur;
        bit [1:0] nxt;
        int       r;
        int       total;

        bus.Enable_i     = 1'b1;
        bus.ClearError_i = 1'b0;
        bus.A_i          = 1'b0;
        bus.B_i          = 1'b0;
        bus.FilterLen_i  = 16'd0;
        model_reset();
        new_seg();
        repeat (3) tick();
        rst_n = 1'b1;
        check_eq("reset_step",  32'(bus.Step_o),      32'd0);
        check_eq("reset_dir",   32'(bus.Direction_o), 32'd0);
        check_eq("reset_error", 32'(bus.Error_o),     32'd0);
        check_eq("reset_state", 32'(bus.State_o),     32'd0);

        // Forward sequence, no filtering
        new_seg();
        drive_hold(1'b1, 1'b0, 4);
        drive_hold(1'b1, 1'b1, 4);
        drive_hold(1'b0, 1'b1, 4);
        drive_hold(1'b0, 1'b0, 6);
        check_eq("fwd_count", 32'(steps_seen), 32'd4);
        check_eq("fwd_first_edge", 32'(first_edge), 32'd3);
        check_eq("fwd_dir", 32'(bus.Direction_o), 32'd0);
        check_eq("fwd_error", 32'(bus.Error_o), 32'd0);

        // Backward sequence, FilterLen 3: each step 6 edges after its raw edge
        bus.FilterLen_i = 16'd3;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            new_seg();
            case (i)
                0: drive_hold(1'b0, 1'b1, 10);
                1: drive_hold(1'b1, 1'b1, 10);
                2: drive_hold(1'b1, 1'b0, 10);
                default: drive_hold(1'b0, 1'b0, 10);
            endcase
            check_eq("bwd_latency", 32'(first_edge), 32'd6);
            total += steps_seen;
        end
        check_eq("bwd_count", 32'(total), 32'd4);
        check_eq("bwd_dir", 32'(bus.Direction_o), 32'd1);

        // Glitch rejection and acceptance at FilterLen 5
        bus.FilterLen_i = 16'd5;
        new_seg();
        drive_hold(1'b1, 1'b0, 5);
        drive_hold(1'b0, 1'b0, 12);
        check_eq("glitch_steps", 32'(steps_seen), 32'd0);
        check_eq("glitch_state", 32'(bus.State_o), 32'd0);
        new_seg();
        drive_hold(1'b1, 1'b0, 6);
        drive_hold(1'b0, 1'b0, 14);
        check_eq("pulse_steps", 32'(steps_seen), 32'd2);
        if (step_dirs.size() == 2) begin
            check_eq("pulse_dir0", 32'(step_dirs[0]), 32'd0);
            check_eq("pulse_dir1", 32'(step_dirs[1]), 32'd1);
        end

        // Illegal double transitions and error clear priority
        bus.FilterLen_i = 16'd0;
        new_seg();
        drive_hold(1'b1, 1'b1, 6);
        check_eq("illegal_steps", 32'(steps_seen), 32'd0);
        check_eq("illegal_error", 32'(bus.Error_o), 32'd1);
        drive_hold(1'b1, 1'b1, 3);
        check_eq("error_sticky", 32'(bus.Error_o), 32'd1);
        bus.A_i = 1'b0;
        bus.B_i = 1'b0;
        tick();
        tick();
        bus.ClearError_i = 1'b1;
        tick();
        bus.ClearError_i = 1'b0;
        check_eq("set_beats_clear", 32'(bus.Error_o), 32'd1);
        repeat (3) tick();
        bus.ClearError_i = 1'b1;
        tick();
        bus.ClearError_i = 1'b0;
        check_eq("error_cleared", 32'(bus.Error_o), 32'd0);

        // Disabled decoding, then a single enabled step
        bus.Enable_i = 1'b0;
        new_seg();
        drive_hold(1'b1, 1'b0, 4);
        check_eq("dis_state_10", 32'(bus.State_o), 32'd2);
        drive_hold(1'b1, 1'b1, 4);
        drive_hold(1'b0, 1'b1, 4);
        drive_hold(1'b0, 1'b0, 6);
        check_eq("dis_steps", 32'(steps_seen), 32'd0);
        bus.Enable_i = 1'b1;
        new_seg();
        drive_hold(1'b1, 1'b0, 6);
        check_eq("reenable_steps", 32'(steps_seen), 32'd1);

        // Asynchronous reset in the middle of a filter count
        drive_hold(1'b0, 1'b0, 6);
        check_eq("pre_reset_dir", 32'(bus.Direction_o), 32'd1);
        bus.FilterLen_i = 16'd5;
        bus.A_i = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_dir",   32'(bus.Direction_o), 32'd0);
        check_eq("async_rst_step",  32'(bus.Step_o),      32'd0);
        check_eq("async_rst_state", 32'(bus.State_o),     32'd0);
        check_eq("async_rst_error", 32'(bus.Error_o),     32'd0);
        tick();
        rst_n = 1'b1;
        new_seg();
        repeat (14) tick();
        check_eq("post_rst_steps", 32'(steps_seen), 32'd1);
        check_eq("post_rst_edge", 32'(first_edge), 32'd8);

        // Randomized walk: legal steps, illegal jumps, glitches, mode changes
        for (int i = 0; i < 500; i++) begin
            cur = {bus.A_i, bus.B_i};
            r   = $urandom_range(0, 9);
            bus.Enable_i     = ($urandom_range(0, 7) != 0);
            bus.ClearError_i = ($urandom_range(0, 5) == 0);
            bus.FilterLen_i  = 16'($urandom_range(0, 4));
            if (r < 6) begin
                nxt = cur ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
                drive_hold(nxt[1], nxt[0], $urandom_range(1, 10));
            end else if (r < 8) begin
                nxt = cur ^ 2'b11;
                drive_hold(nxt[1], nxt[0], $urandom_range(1, 10));
            end else begin
                nxt = cur ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
                drive_hold(nxt[1], nxt[0], $urandom_range(1, 3));
                drive_hold(cur[1], cur[0], $urandom_range(1, 10));
            end
        end
        bus.ClearError_i = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
